// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: oversampled frame capture, scan-code FIFO and 2-digit hex display.
// Optional macro PS2_PARITY_CHK_EN rejects frames that fail the odd-parity check.
module ps2_keyboard #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] o_seg0,
  output logic [7:0] o_seg1
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [7:0] hex7seg(input logic [3:0] n);
    case (n)
      4'h0: hex7seg = 8'hC0;  4'h1: hex7seg = 8'hF9;
      4'h2: hex7seg = 8'hA4;  4'h3: hex7seg = 8'hB0;
      4'h4: hex7seg = 8'h99;  4'h5: hex7seg = 8'h92;
      4'h6: hex7seg = 8'h82;  4'h7: hex7seg = 8'hF8;
      4'h8: hex7seg = 8'h80;  4'h9: hex7seg = 8'h90;
      4'hA: hex7seg = 8'h88;  4'hB: hex7seg = 8'h83;
      4'hC: hex7seg = 8'hC6;  4'hD: hex7seg = 8'hA1;
      4'hE: hex7seg = 8'h86;  default: hex7seg = 8'h8E;
    endcase
  endfunction

  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] idle_cnt;
  logic          frame_done;
  logic          frame_ok;
  logic          par_ok;
  logic [7:0]    frame_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;

  assign fall = clk_sync[2] & ~clk_sync[1];

  // Bits shift in from the top, so after ten samples shreg[0] holds the start bit.
  always_comb begin
    frame_done = fall && (bit_cnt == 4'd10);
    frame_byte = shreg[8:1];
`ifdef PS2_PARITY_CHK_EN
    par_ok     = ^shreg[9:1];
`else
    par_ok     = 1'b1;
`endif
    frame_ok   = ~shreg[0] & dat_sync[1] & par_ok;
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign ready = (count != '0);
  assign pop   = ~nextdata_n & ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push  = frame_done & frame_ok & (~full | pop);
  assign data  = ready ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      o_seg0    <= '1;
      o_seg1    <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      frame_err <= frame_done & ~frame_ok;

      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {dat_sync[1], shreg[9:1]};
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end

      if (frame_done && frame_ok) begin
        o_seg0 <= hex7seg(frame_byte[3:0]);
        o_seg1 <= hex7seg(frame_byte[7:4]);
        if (full && !pop) overflow <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= frame_byte;
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: frames are driven by a keyboard model, codes are checked on pop.
module tb_ps2_keyboard;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 300;
  localparam int unsigned HALF  = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic [7:0] o_seg0;
  logic [7:0] o_seg1;

  int   tests = 0;
  int   fails = 0;
  int   err_pulses = 0;
  int   e0;
  bit   pop_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] ovf_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h5A};
  logic [7:0] seq_codes [3] = '{8'h1C, 8'hF0, 8'h1C};

  ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .o_seg0    (o_seg0),
    .o_seg1    (o_seg1)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops whenever enabled and the DUT presents data, comparing against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (pop_en && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_data: got %0h expected none", data);
      end else begin
        check("fifo_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
      end
      nextdata_n = 1'b0;
    end else begin
      nextdata_n = 1'b1;
    end
  end

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] b;
    b = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic drain(input string name);
    pop_en = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    pop_en = 1'b0;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_ready_after"}, {31'h0, ready}, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_ready", {31'h0, ready}, 0);
    check("rst_data", {24'h0, data}, 0);
    check("rst_overflow", {31'h0, overflow}, 0);
    check("rst_frame_err", {31'h0, frame_err}, 0);
    check("rst_seg0", {24'h0, o_seg0}, 32'hFF);
    check("rst_seg1", {24'h0, o_seg1}, 32'hFF);

    // Single code
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    @(negedge clk);
    check("one_ready", {31'h0, ready}, 1);
    check("one_data", {24'h0, data}, 32'h1C);
    check("one_seg1", {24'h0, o_seg1}, 32'hF9);
    check("one_seg0", {24'h0, o_seg0}, 32'hC6);
    exp_q.push_back(8'h1C);
    drain("one");

    // Make/break sequence popped in order
    foreach (seq_codes[i]) begin
      send_frame(seq_codes[i], 1'b0, 1'b0, 11);
      exp_q.push_back(seq_codes[i]);
    end
    drain("seq");

    // Overflow: nine frames into an eight-entry FIFO
    for (int i = 0; i < 8; i++) begin
      send_frame(ovf_codes[i], 1'b0, 1'b0, 11);
      exp_q.push_back(ovf_codes[i]);
    end
    @(negedge clk);
    check("full_no_overflow", {31'h0, overflow}, 0);
    send_frame(ovf_codes[8], 1'b0, 1'b0, 11);
    @(negedge clk);
    check("ovf_overflow", {31'h0, overflow}, 1);
    check("ovf_seg1", {24'h0, o_seg1}, 32'h92);
    check("ovf_seg0", {24'h0, o_seg0}, 32'h88);
    drain("ovf");
    check("ovf_sticky", {31'h0, overflow}, 1);
    do_reset();
    check("reset_clears_overflow", {31'h0, overflow}, 0);

    // Bad stop bit
    e0 = err_pulses;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    @(negedge clk);
    check("stop_err_pulses", err_pulses - e0, 1);
    check("stop_ready", {31'h0, ready}, 0);
    check("stop_seg0", {24'h0, o_seg0}, 32'hFF);
    check("stop_seg1", {24'h0, o_seg1}, 32'hFF);

    // Bad parity
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    @(negedge clk);
`ifdef PS2_PARITY_CHK_EN
    check("par_err_pulses", err_pulses - e0, 1);
    check("par_ready", {31'h0, ready}, 0);
`else
    check("par_err_pulses", err_pulses - e0, 0);
    check("par_data", {24'h0, data}, 32'h1C);
    exp_q.push_back(8'h1C);
    drain("par");
`endif

    // Partial frame aborted by timeout, then a clean frame
    e0 = err_pulses;
    send_frame(8'hFF, 1'b0, 1'b0, 5);
    repeat (TMO + 1) @(posedge clk);
    send_frame(8'h29, 1'b0, 1'b0, 11);
    @(negedge clk);
    check("tmo_ready", {31'h0, ready}, 1);
    check("tmo_data", {24'h0, data}, 32'h29);
    check("tmo_err_pulses", err_pulses - e0, 0);
    check("tmo_seg1", {24'h0, o_seg1}, 32'hA4);
    check("tmo_seg0", {24'h0, o_seg0}, 32'h90);
    exp_q.push_back(8'h29);
    drain("tmo");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
